// File: rtl/jk_register_bank_if.sv
// jk_register_bank_if
//   Bundles the control, data and status signals of jk_register_bank.
//   master : the controlling side (drives en/mode/j/k/dir/ser_in, reads outputs)
//   slave  : the register bank itself (reads controls, drives q/q_n/tc/ser_out)
//   Signals:
//     en      update enable, 0 holds all state
//     mode    00 JK, 01 COUNT, 10 SHIFT, 11 LOAD
//     j, k    per-bit J/K inputs; j doubles as parallel load data
//     dir     COUNT 0 up / 1 down; SHIFT 0 left / 1 right
//     ser_in  serial input for SHIFT
//     q, q_n  registered state and its complement
//     tc      registered terminal-count pulse
//     ser_out registered bit shifted out on the last SHIFT edge
interface jk_register_bank_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             dir;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             tc;
  logic             ser_out;

  modport master (
    output en, mode, j, k, dir, ser_in,
    input  q, q_n, tc, ser_out
  );

  modport slave (
    input  en, mode, j, k, dir, ser_in,
    output q, q_n, tc, ser_out
  );
endinterface

// File: rtl/jk_register_bank.sv
// jk_register_bank
//   Bank of WIDTH JK flip-flops with four run-time modes: per-bit JK,
//   up/down counter built from a toggle chain, bidirectional shift register
//   and parallel load. All outputs are registered.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset (overrides everything)
//     bus  jk_register_bank_if slave modport (controls in, q/q_n/tc/ser_out out)
module jk_register_bank #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  jk_register_bank_if.slave bus
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_n_reg;
  logic             tc_reg;
  logic             ser_out_reg;

  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             ser_out_next;
  logic             wrap;

  // Toggle chain: bit i flips when every lower bit is 1 (up) or 0 (down).
  // Written as a running AND so synthesis can build a prefix tree for wide banks.
  always_comb begin
    toggle    = '0;
    toggle[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & (bus.dir ? ~q_reg[i-1] : q_reg[i-1]);
    end
  end

  // Wrap happens exactly when the whole chain toggles: all-ones going up, zero going down.
  assign wrap = bus.dir ? (q_reg == '0) : (&q_reg);

  always_comb begin
    q_next       = q_reg;
    tc_next      = 1'b0;
    ser_out_next = ser_out_reg;
    case (bus.mode)
      MODE_JK: begin
        q_next = (bus.j & ~q_reg) | (~bus.k & q_reg);
      end
      MODE_COUNT: begin
        q_next  = q_reg ^ toggle;
        tc_next = wrap;
      end
      MODE_SHIFT: begin
        if (bus.dir) begin
          q_next       = {bus.ser_in, q_reg[WIDTH-1:1]};
          ser_out_next = q_reg[0];
        end else begin
          q_next       = {q_reg[WIDTH-2:0], bus.ser_in};
          ser_out_next = q_reg[WIDTH-1];
        end
      end
      MODE_LOAD: begin
        q_next = bus.j;
      end
      default: begin
        q_next = q_reg;
      end
    endcase
  end

  // q_n is a separate register loaded with the complement of the next state,
  // so it is never a cycle behind q. tc is a pulse and clears when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      q_n_reg     <= '1;
      tc_reg      <= 1'b0;
      ser_out_reg <= 1'b0;
    end else if (!bus.en) begin
      tc_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      q_n_reg     <= ~q_next;
      tc_reg      <= tc_next;
      ser_out_reg <= ser_out_next;
    end
  end

  assign bus.q       = q_reg;
  assign bus.q_n     = q_n_reg;
  assign bus.tc      = tc_reg;
  assign bus.ser_out = ser_out_reg;

endmodule

// File: tb/tb_jk_register_bank.sv
// tb_jk_register_bank
//   Directed testbench for jk_register_bank at WIDTH=4. Each scenario task
//   drives its vectors and compares outputs against hand-computed values.
module tb_jk_register_bank;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  jk_register_bank_if #(.WIDTH(W)) bus ();

  jk_register_bank #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs away from the rising edge, clock once, and
  // return 1 time unit after the edge so outputs are stable for checking.
  task automatic drive_edge(input logic r, input logic e, input logic [1:0] m,
                            input logic [W-1:0] jv, input logic [W-1:0] kv,
                            input logic d, input logic si);
    @(negedge clk);
    rst        = r;
    bus.en     = e;
    bus.mode   = m;
    bus.j      = jv;
    bus.k      = kv;
    bus.dir    = d;
    bus.ser_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_edge(1'b1, 1'b1, 2'b11, 4'b1111, 4'b0101, 1'b0, 1'b1);
    drive_edge(1'b1, 1'b0, 2'b01, 4'b0110, 4'b1001, 1'b1, 1'b1);
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("[TB] FAIL reset_q got=%b exp=0000", bus.q); end
    checks++; if (bus.q_n !== 4'b1111) begin errors++; $display("[TB] FAIL reset_q_n got=%b exp=1111", bus.q_n); end
    checks++; if (bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc got=%b exp=0", bus.tc); end
    checks++; if (bus.ser_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_ser_out got=%b exp=0", bus.ser_out); end
    drive_edge(1'b0, 1'b0, 2'b11, 4'b1111, 4'b0000, 1'b0, 1'b1);
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("[TB] FAIL reset_hold_q got=%b exp=0000", bus.q); end
    checks++; if (bus.q_n !== 4'b1111) begin errors++; $display("[TB] FAIL reset_hold_q_n got=%b exp=1111", bus.q_n); end
  endtask

  task automatic test_jk();
    logic [W-1:0] jv [4] = '{4'b1010, 4'b0000, 4'b1111, 4'b0000};
    logic [W-1:0] kv [4] = '{4'b0000, 4'b0010, 4'b1111, 4'b0000};
    logic [W-1:0] ex [4] = '{4'b1010, 4'b1000, 4'b0111, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, 1'b1, 2'b00, jv[i], kv[i], 1'b0, 1'b0);
      checks++; if (bus.q !== ex[i]) begin errors++; $display("[TB] FAIL jk_q step=%0d got=%b exp=%b", i, bus.q, ex[i]); end
      checks++; if (bus.q_n !== ~ex[i]) begin errors++; $display("[TB] FAIL jk_q_n step=%0d got=%b exp=%b", i, bus.q_n, ~ex[i]); end
      checks++; if (bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL jk_tc step=%0d got=%b exp=0", i, bus.tc); end
    end
  endtask

  task automatic test_count();
    logic         dv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] ex [5] = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b1111};
    logic         et [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    drive_edge(1'b0, 1'b1, 2'b11, 4'b1110, 4'b0101, 1'b0, 1'b0);
    checks++; if (bus.q !== 4'b1110) begin errors++; $display("[TB] FAIL count_load got=%b exp=1110", bus.q); end
    for (int i = 0; i < 5; i++) begin
      drive_edge(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, dv[i], 1'b0);
      checks++; if (bus.q !== ex[i]) begin errors++; $display("[TB] FAIL count_q step=%0d got=%b exp=%b", i, bus.q, ex[i]); end
      checks++; if (bus.tc !== et[i]) begin errors++; $display("[TB] FAIL count_tc step=%0d got=%b exp=%b", i, bus.tc, et[i]); end
      checks++; if (bus.q_n !== ~ex[i]) begin errors++; $display("[TB] FAIL count_q_n step=%0d got=%b exp=%b", i, bus.q_n, ~ex[i]); end
    end
  endtask

  task automatic test_shift();
    drive_edge(1'b0, 1'b1, 2'b11, 4'b1001, 4'b0000, 1'b0, 1'b0);
    drive_edge(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b0, 1'b1);
    checks++; if (bus.q !== 4'b0011) begin errors++; $display("[TB] FAIL shl_q got=%b exp=0011", bus.q); end
    checks++; if (bus.ser_out !== 1'b1) begin errors++; $display("[TB] FAIL shl_ser_out got=%b exp=1", bus.ser_out); end
    drive_edge(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checks++; if (bus.q !== 4'b0001) begin errors++; $display("[TB] FAIL shr1_q got=%b exp=0001", bus.q); end
    checks++; if (bus.ser_out !== 1'b1) begin errors++; $display("[TB] FAIL shr1_ser_out got=%b exp=1", bus.ser_out); end
    drive_edge(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("[TB] FAIL shr2_q got=%b exp=0000", bus.q); end
    checks++; if (bus.ser_out !== 1'b1) begin errors++; $display("[TB] FAIL shr2_ser_out got=%b exp=1", bus.ser_out); end
    checks++; if (bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL shr2_tc got=%b exp=0", bus.tc); end
    // Shifting a zero out next, then loading, shows ser_out tracks only SHIFT edges.
    drive_edge(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checks++; if (bus.ser_out !== 1'b0) begin errors++; $display("[TB] FAIL shr3_ser_out got=%b exp=0", bus.ser_out); end
    drive_edge(1'b0, 1'b1, 2'b11, 4'b1001, 4'b0110, 1'b0, 1'b1);
    checks++; if (bus.q !== 4'b1001) begin errors++; $display("[TB] FAIL load_after_shift_q got=%b exp=1001", bus.q); end
    checks++; if (bus.ser_out !== 1'b0) begin errors++; $display("[TB] FAIL load_ser_out_hold got=%b exp=0", bus.ser_out); end
  endtask

  task automatic test_enable_reset();
    logic         ev [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] ex [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0011,
                             4'b0011, 4'b0100, 4'b0100, 4'b0101};
    // tc must drop on a disabled edge even right after a wrap.
    drive_edge(1'b0, 1'b1, 2'b11, 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive_edge(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (bus.tc !== 1'b1) begin errors++; $display("[TB] FAIL en_wrap_tc got=%b exp=1", bus.tc); end
    drive_edge(1'b0, 1'b0, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL en_off_tc got=%b exp=0", bus.tc); end
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("[TB] FAIL en_off_q got=%b exp=0000", bus.q); end
    for (int i = 0; i < 9; i++) begin
      drive_edge(1'b0, ev[i], 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0);
      checks++; if (bus.q !== ex[i]) begin errors++; $display("[TB] FAIL en_toggle_q step=%0d got=%b exp=%b", i, bus.q, ex[i]); end
      checks++; if (bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL en_toggle_tc step=%0d got=%b exp=0", i, bus.tc); end
    end
    drive_edge(1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset_q got=%b exp=0000", bus.q); end
    checks++; if (bus.q_n !== 4'b1111) begin errors++; $display("[TB] FAIL mid_reset_q_n got=%b exp=1111", bus.q_n); end
    drive_edge(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (bus.q !== 4'b0001) begin errors++; $display("[TB] FAIL resume_q got=%b exp=0001", bus.q); end
  endtask

  task automatic test_mode_switch();
    drive_edge(1'b0, 1'b1, 2'b11, 4'b0110, 4'b0000, 1'b0, 1'b0);
    drive_edge(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (bus.q !== 4'b0111) begin errors++; $display("[TB] FAIL switch_count_q got=%b exp=0111", bus.q); end
    drive_edge(1'b0, 1'b1, 2'b11, 4'b1100, 4'b1111, 1'b0, 1'b0);
    checks++; if (bus.q !== 4'b1100) begin errors++; $display("[TB] FAIL switch_load_q got=%b exp=1100", bus.q); end
    checks++; if (bus.q_n !== 4'b0011) begin errors++; $display("[TB] FAIL switch_load_q_n got=%b exp=0011", bus.q_n); end
  endtask

  task automatic test_back_to_back();
    // Down count from 0001 across zero, then straight into an up count.
    drive_edge(1'b0, 1'b1, 2'b11, 4'b0001, 4'b0000, 1'b0, 1'b0);
    drive_edge(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checks++; if (bus.q !== 4'b0000 || bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL b2b_down1 got=%b/%b exp=0000/0", bus.q, bus.tc); end
    drive_edge(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checks++; if (bus.q !== 4'b1111 || bus.tc !== 1'b1) begin errors++; $display("[TB] FAIL b2b_down2 got=%b/%b exp=1111/1", bus.q, bus.tc); end
    drive_edge(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (bus.q !== 4'b0000 || bus.tc !== 1'b1) begin errors++; $display("[TB] FAIL b2b_up got=%b/%b exp=0000/1", bus.q, bus.tc); end
    drive_edge(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checks++; if (bus.q !== 4'b0001 || bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL b2b_up2 got=%b/%b exp=0001/0", bus.q, bus.tc); end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.mode   = 2'b00;
    bus.j      = '0;
    bus.k      = '0;
    bus.dir    = 1'b0;
    bus.ser_in = 1'b0;
    test_reset();
    test_jk();
    test_count();
    test_shift();
    test_enable_reset();
    test_mode_switch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_register_bank.md
# jk_register_bank

Parametrised bank of WIDTH JK flip-flops sharing one clock and one synchronous reset. It generalises the single JK flip-flop into a multi-bit register with four run-time modes: per-bit JK, binary up/down counter built from a toggle chain, bidirectional shift register, and parallel load. It is the standard register and counter primitive for lab datapaths, driving counters, shifters and status registers from one block.

## Interface
- WIDTH, 8, number of flip-flops in the bank (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- en  in  1  update enable; 0 = hold all state
- mode  in  2  00 JK, 01 COUNT, 10 SHIFT, 11 LOAD
- j  in  WIDTH  per-bit J inputs (JK mode); parallel data (LOAD mode)
- k  in  WIDTH  per-bit K inputs (JK mode only)
- dir  in  1  COUNT: 0 up / 1 down; SHIFT: 0 left (toward MSB) / 1 right
- ser_in  in  1  serial input bit for SHIFT mode
- q  out  WIDTH  registered state
- q_n  out  WIDTH  registered complement; always equals ~q, including the cycle after reset
- tc  out  1  registered terminal-count flag
- ser_out  out  1  bit shifted out on the last SHIFT edge (registered)

## Operation
- All state updates happen on the rising edge of clk. There is no other storage.
- rst=1 (highest priority, overrides en/mode): q=0, q_n=all ones, tc=0, ser_out=0.
- en=0: q, q_n and ser_out hold. tc is cleared to 0.
- JK mode (00), per bit i:
  - j=1, k=0: set.
  - j=0, k=1: clear.
  - j=1, k=1: toggle.
  - j=0, k=0: hold.
  - tc=0. ser_out holds.
- COUNT mode (01):
  - Up: q <= q+1 mod 2^WIDTH. Down: q <= q−1 mod 2^WIDTH.
  - Implemented as a toggle chain. Bit 0 always toggles. Bit i toggles when bits 0..i−1 are all 1 (up) or all 0 (down).
  - tc <= 1 only on the edge where q wraps: all-ones→0 when up, 0→all-ones when down. Otherwise tc <= 0.
  - ser_out holds.
- SHIFT mode (10):
  - Left: q <= {q[WIDTH−2:0], ser_in}, ser_out <= old q[WIDTH−1].
  - Right: q <= {ser_in, q[WIDTH−1:1]}, ser_out <= old q[0].
  - tc=0.
- LOAD mode (11): q <= j. k is ignored. tc=0. ser_out holds.
- q_n is updated on the same edge as q and is never stale.
- mode and dir are sampled at each edge. A change takes effect on the first edge where the new value is present, with no pipeline or flush.

## Timing
- Latency is 1 cycle from input sampling to q, q_n, tc and ser_out.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- tc is a single-cycle pulse per wrap. In continuous counting with WIDTH=4 it pulses once every 16 cycles.
- Reset asserted in the middle of a count or shift wins on that edge. The block resumes from q=0 on the first edge after rst falls.
- If en and rst are both high, reset applies.
- Toggle-chain carry is combinational across WIDTH bits within one cycle and must meet timing at WIDTH=32.

## Test plan
All scenarios use WIDTH=4.
- Reset: drive rst=1 for 2 cycles with arbitrary en, mode, j and k → q=0000, q_n=1111, tc=0, ser_out=0. Release rst with en=0 → values hold.
- JK truth table: mode=00, en=1, start from q=0000. Apply j=1010/k=0000 → 1010. Then j=0000/k=0010 → 1000. Then j=1111/k=1111 → 0111. Then j=0000/k=0000 → 0111 holds. Check q_n=~q after every edge.
- Count up and wrap: LOAD 1110, then COUNT up for 3 edges → q = 1111, 0000, 0001, with tc = 0, 1, 0. Switch dir=1 for 2 edges → 0000, then 1111 with tc=1 on the 1111 edge.
- Shift: LOAD 1001. Shift left with ser_in=1 → q=0011, ser_out=1. Shift right with ser_in=0 → q=0001, ser_out=1. Shift right again → q=0000, ser_out=1.
- Enable and mid-operation reset: count up from 0000 with en toggling every cycle → q advances only on edges where en=1, and tc=0 on edges where en=0. At q=0101, assert rst for 1 edge → q=0000. The next count edge gives q=0001.
- Mode switch: at q=0111 in COUNT up, switch to LOAD with j=1100 on the next edge → q=1100, with no increment applied.
